// File: rtl/multi_reset_debouncer.sv
// multi_reset_debouncer: per-channel 2-flop sync + symmetric debounce filter.
// Ports: clk, reset_n (async low), raw_in[CHANNELS], tick (sample enable)
//        -> debounced, rise_pulse, fall_pulse, long_press (all [CHANNELS]).
// Optional macro LONG_PRESS_EN builds per-channel hold counters that pulse
// long_press once per press after LONG_LIMIT ticked samples held high;
// without it long_press is tied low.
module multi_reset_debouncer #(
    parameter int CHANNELS   = 4,
    parameter int LIMIT      = 1000,
    parameter int CNT_W      = 10,
    parameter int LONG_LIMIT = 50000,
    parameter int LONG_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic                tick,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

    logic [CHANNELS-1:0] s1_q, s2_q;
    logic [CHANNELS-1:0] deb_q, deb_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    always_comb begin
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (s2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    // New level held for LIMIT ticked samples: accept it.
                    deb_d[i]  = s2_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= raw_in;
            s2_q   <= s1_q;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign debounced  = deb_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_LIMIT - 1);

    logic [LONG_W-1:0]   lcnt_q [CHANNELS];
    logic [LONG_W-1:0]   lcnt_d [CHANNELS];
    logic [CHANNELS-1:0] armed_q, armed_d;
    logic [CHANNELS-1:0] lp_q, lp_d;

    // Counter saturates at LONG_MAX; the armed bit limits the pulse to
    // one per press and is restored only while the level is low.
    always_comb begin
        armed_d = armed_q;
        lp_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lcnt_d[i] = lcnt_q[i];
            if (!deb_q[i]) begin
                lcnt_d[i]  = '0;
                armed_d[i] = 1'b1;
            end else if (tick) begin
                if (lcnt_q[i] == LONG_MAX) begin
                    if (armed_q[i]) begin
                        lp_d[i]    = 1'b1;
                        armed_d[i] = 1'b0;
                    end
                end else begin
                    lcnt_d[i] = lcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= '0;
            lp_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                lcnt_q[i] <= '0;
            end
        end else begin
            armed_q <= armed_d;
            lp_q    <= lp_d;
            for (int i = 0; i < CHANNELS; i++) begin
                lcnt_q[i] <= lcnt_d[i];
            end
        end
    end

    assign long_press = lp_q;
`else
    assign long_press = '0;
`endif

endmodule

// File: doc/multi_reset_debouncer.md
Name: multi_reset_debouncer

Overview:
Parametrised multi-channel debouncer for push-button and reset inputs on the FP adder board.
- Each channel: two-flop synchroniser, then symmetric debounce filter covering both press and release.
- Outputs per channel: clean level, one-cycle rise pulse and one-cycle fall pulse.
- A shared sample tick lets one prescaler slow all filters.
- Sits between raw board pins and core control logic (adder reset, operand-load strobes).

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
LIMIT, 1000, consecutive ticked samples of a new level required before it is accepted (>=1)
CNT_W, 10, width of each per-channel counter; 2**CNT_W > LIMIT-1 is required
LONG_LIMIT, 50000, ticked samples of a held press that raise long_press (only used with LONG_PRESS_EN)
LONG_W, 16, width of each long-press counter; 2**LONG_W > LONG_LIMIT-1 is required

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
raw_in  input  CHANNELS  raw asynchronous button/reset levels, active high
tick  input  1  sample enable; filter counters advance only when 1 (tie to 1 for every-cycle sampling)
debounced  output  CHANNELS  filtered stable level per channel
rise_pulse  output  CHANNELS  one-clk pulse when debounced[i] goes 0->1
fall_pulse  output  CHANNELS  one-clk pulse when debounced[i] goes 1->0
long_press  output  CHANNELS  one-clk pulse on long hold (see Optional Feature)

Behaviour:
Reset
- reset_n low clears asynchronously: synchroniser flops, counters, debounced, rise_pulse, fall_pulse, long_press all go to 0.
- Reset mid-debounce discards the partial count.

Synchroniser
- Per channel: s1 <= raw_in[i], s2 <= s1 on every clk, independent of tick.

Filter, evaluated per channel on each clk where tick=1
- If s2 == debounced[i]: cnt <= 0.
- Else if cnt == LIMIT-1: debounced[i] <= s2; cnt <= 0; pulse rise/fall.
- Else: cnt <= cnt+1.
- When tick=0: cnt and debounced hold.

Pulse rules
- rise_pulse[i]/fall_pulse[i] are high for exactly one clk, on the cycle after debounced[i] changes; low otherwise.
- Never both high on the same channel.

Latency, tick=1
- A clean level change first sampled at edge 1 appears on debounced at edge LIMIT+2.
- Pulse is visible for the clk following that edge.

Bounce handling
- Any ticked sample equal to the current debounced value restarts the count.
- Glitches shorter than LIMIT ticked samples never reach debounced.

Channel independence
- Channels share only tick.
- Simultaneous changes on several channels are each processed independently in the same cycle.

Counter width
- cnt never exceeds LIMIT-1, so it never wraps.

Optional Feature:
Macro: LONG_PRESS_EN
- Defined:
  - Per-channel hold counter, cleared while debounced[i]=0; increments on ticked cycles while debounced[i]=1.
  - When it reaches LONG_LIMIT-1, long_press[i] pulses for one clk and the counter saturates.
  - Only one pulse per press; re-arms after debounced[i] returns to 0.
  - Reset clears it.
- Undefined: no hold counters are built; long_press is driven constant 0.

Test Plan:
1. CHANNELS=4, LIMIT=4, tick=1; reset_n low 3 clk then high, raw_in=0 -> all outputs 0 throughout and after release.
2. raw_in[0] 0->1 clean, first sampled edge 1 -> debounced[0]=1 after edge 6; rise_pulse[0] high for exactly that one clk; other channels stay 0.
3. raw_in[1] bounces 1,0,1,1,0 (one clk each) then holds 1 -> no change until 4 consecutive ticked 1-samples after s2 settles; exactly one rise_pulse[1]; zero spurious pulses during the bounce.
4. Channel 2 high, then raw_in[2] 1->0 held -> debounced[2]=0 after 6 edges, fall_pulse[2] single pulse; simultaneous rise on channel 3 occurs in the same cycle.
5. tick asserted 1 clk in 3, raw_in[0] 0->1 -> debounced[0] changes only after 4 ticked samples; counter holds on untick cycles; pulse still one clk wide.
6. Assert reset_n mid-count (cnt=2) on channel 1 -> outputs 0 immediately; after release the full LIMIT count restarts. With LONG_PRESS_EN and LONG_LIMIT=8: hold a press -> exactly one long_press pulse 8 ticks after debounce; without the macro long_press stays 0.
